// File: rtl/serial_sub_if.sv
// Handshake bundle for serial_sub: operand request channel and result channel.
//   in_valid/in_ready/opa/opb  : operand pair offered by the producer
//   out_valid/out_ready        : result handshake toward the consumer
//   diff/borrow                : registered result
//   busy                       : unit is not idle
// master = producer/consumer side, slave = serial_sub.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;

  modport master (
    output in_valid, opa, opb, out_ready,
    input  in_ready, out_valid, diff, borrow, busy
  );

  modport slave (
    input  in_valid, opa, opb, out_ready,
    output in_ready, out_valid, diff, borrow, busy
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtract-with-borrow: diff = opa - opb, LSB first, one bit per clock.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_sub_if.slave (operand handshake, result handshake, busy)
// Optional feature: define SERIAL_SUB_SAT_EN for unsigned saturation
// (diff forced to 0 when the final borrow is 1).
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   diff_q;
  logic               br;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               d_bit;
  logic               br_nxt;
  logic               last_bit;
  logic               accept;

  // Next-state and full-subtractor bit logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    d_bit     = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    last_bit  = (cnt == CNT_W'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; status flags are registered copies of the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
      busy_q      <= (state_nxt != IDLE);
    end
  end

  // Operand shifters, running borrow, partial difference and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.opa;
      b_sr <= bus.opb;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      br     <= br_nxt;
      cnt    <= cnt + CNT_W'(1);
      diff_q <= {d_bit, diff_q[WIDTH-1:1]};
      if (last_bit) begin
        borrow_q <= br_nxt;
`ifdef SERIAL_SUB_SAT_EN
        // Underflow clamps to zero; borrow still flags it
        if (br_nxt) diff_q <= '0;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=8).
// Define SERIAL_SUB_SAT_EN to check the saturating build.
`timescale 1ns/1ps
module tb_serial_sub;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  serial_sub_if #(.WIDTH(WIDTH)) bus ();

  serial_sub #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, count latency, check result, drain.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb);
    int lat;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.opa      = a;
    bus.opb      = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".diff"},    32'(bus.diff), 32'(ed));
    check({tag, ".borrow"},  32'(bus.borrow), 32'(eb));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".drain"}, 32'({bus.out_valid, bus.busy, bus.in_ready}), 32'b001);
  endtask

  logic [7:0] pa [4];
  logic [7:0] pb [4];
  logic [7:0] ed_m [4];
  logic       eb_m [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.opa       = '0;
    bus.opb       = '0;
    rst_n         = 1'b0;
    #22;
    check("rst.flags", 32'({bus.out_valid, bus.busy, bus.in_ready}), 32'b001);
    check("rst.result", 32'({bus.borrow, bus.diff}), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic and boundary vectors
    run_op("t1", 8'h5A, 8'h21, 8'h39, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
    run_op("t2", 8'h10, 8'h20, 8'h00, 1'b1);
    run_op("t3b", 8'h00, 8'h01, 8'h00, 1'b1);
`else
    run_op("t2", 8'h10, 8'h20, 8'hF0, 1'b1);
    run_op("t3b", 8'h00, 8'h01, 8'hFF, 1'b1);
`endif
    run_op("t3a", 8'hFF, 8'hFF, 8'h00, 1'b0);
    run_op("opb0", 8'hC3, 8'h00, 8'hC3, 1'b0);

    // Stall in DONE with in_valid pulsing: result and flags must hold
    bus.opa = 8'h9C;
    bus.opb = 8'h1D;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.opa = 8'(i);
      check("t4.out_valid", 32'(bus.out_valid), 32'd1);
      check("t4.in_ready",  32'(bus.in_ready), 32'd0);
      check("t4.result",    32'({bus.borrow, bus.diff}), 32'h07F);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    check("t4.no_capture", 32'({bus.busy, bus.in_ready}), 32'b01);

    // Reset during the 4th SHIFT cycle
    bus.opa = 8'h33;
    bus.opb = 8'h11;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.flags",  32'({bus.out_valid, bus.busy, bus.in_ready}), 32'b001);
    check("t5.result", 32'({bus.borrow, bus.diff}), 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    run_op("t5.post", 8'h80, 8'h01, 8'h7F, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 4; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
      eb_m[i] = (pa[i] < pb[i]);
      ed_m[i] = pa[i] - pb[i];
`ifdef SERIAL_SUB_SAT_EN
      if (eb_m[i]) ed_m[i] = 8'h00;
`endif
    end
    begin
      int idx_in;
      int idx_out;
      int last_cyc;
      logic fire_in;
      logic fire_out;
      logic [8:0] obs;
      idx_in   = 0;
      idx_out  = 0;
      last_cyc = 0;
      bus.opa  = pa[0];
      bus.opb  = pb[0];
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && idx_out < 4; cyc++) begin
        fire_in  = bus.in_valid & bus.in_ready;
        fire_out = bus.out_valid & bus.out_ready;
        obs      = {bus.borrow, bus.diff};
        tick();
        if (fire_in) begin
          idx_in++;
          if (idx_in < 4) begin
            bus.opa = pa[idx_in];
            bus.opb = pb[idx_in];
          end else begin
            bus.in_valid = 1'b0;
          end
        end
        if (fire_out) begin
          check("t6.result", 32'(obs), 32'({eb_m[idx_out], ed_m[idx_out]}));
          if (idx_out > 0) check("t6.period", 32'(cyc - last_cyc), 32'd10);
          last_cyc = cyc;
          idx_out++;
        end
      end
      check("t6.count", 32'(idx_out), 32'd4);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
